// File: rtl/pc_bpred_pkg.sv
// Shared types and helpers for the fetch-stage PC and branch target buffer.
package pc_bpred_pkg;

  // Two-bit saturating direction counter; the MSB is the taken prediction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } btb_ctr_t;

  // One BTB line. The tag field is sized for the smallest index (IDX_W=0);
  // deeper tables zero-extend their narrower tag into it.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
    btb_ctr_t    ctr;
  } btb_entry_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Strengthen towards taken, saturating at ST.
  function automatic btb_ctr_t sat_inc(input btb_ctr_t c);
    case (c)
      SNT:     sat_inc = WNT;
      WNT:     sat_inc = WT;
      WT:      sat_inc = ST;
      ST:      sat_inc = ST;
      default: sat_inc = WNT;
    endcase
  endfunction

  // Strengthen towards not-taken, saturating at SNT.
  function automatic btb_ctr_t sat_dec(input btb_ctr_t c);
    case (c)
      SNT:     sat_dec = SNT;
      WNT:     sat_dec = SNT;
      WT:      sat_dec = WNT;
      ST:      sat_dec = WT;
      default: sat_dec = WNT;
    endcase
  endfunction

endpackage

// File: rtl/pc_bpred_btb.sv
// Direct-mapped branch target buffer: combinational lookup, one update port.
module pc_bpred_btb
  import pc_bpred_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] lookup_pc,
  output logic        lookup_hit,
  output logic        lookup_ctr_msb,
  output logic [31:0] lookup_target,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  btb_entry_t       mem_r [ENTRIES];
  btb_entry_t       lk_entry_s;
  btb_entry_t       up_entry_s;
  btb_entry_t       nxt_entry_s;
  logic [IDX_W-1:0] lk_idx_s;
  logic [IDX_W-1:0] up_idx_s;
  logic             up_hit_s;
  logic             wr_s;
  logic             unused_s;

  // Tag of a PC, zero-extended into the entry's tag field.
  function automatic logic [29:0] tag_of(input logic [31:0] pc);
    logic [29:0] t;
    t = 30'd0;
    t[TAG_W-1:0] = pc[31:IDX_W+2];
    return t;
  endfunction

  assign lk_idx_s = lookup_pc[IDX_W+1:2];
  assign up_idx_s = upd_pc[IDX_W+1:2];
  // Byte-offset bits never take part in indexing or tagging.
  assign unused_s = ^{lookup_pc[1:0], upd_pc[1:0]};

  // Lookup reads the stored line, so a same-cycle write is seen only next cycle.
  always_comb begin
    lk_entry_s     = mem_r[lk_idx_s];
    lookup_hit     = lk_entry_s.valid && (lk_entry_s.tag == tag_of(lookup_pc));
    lookup_ctr_msb = lk_entry_s.ctr[1];
    lookup_target  = lk_entry_s.target;
  end

  // Decide whether and how the indexed line changes for a resolved branch.
  always_comb begin
    up_entry_s  = mem_r[up_idx_s];
    up_hit_s    = up_entry_s.valid && (up_entry_s.tag == tag_of(upd_pc));
    nxt_entry_s = up_entry_s;
    wr_s        = 1'b0;
    if (upd_en) begin
      if (up_hit_s) begin
        wr_s = 1'b1;
        if (upd_taken) begin
          nxt_entry_s.ctr    = sat_inc(up_entry_s.ctr);
          nxt_entry_s.target = upd_target;
        end else begin
          nxt_entry_s.ctr    = sat_dec(up_entry_s.ctr);
        end
      end else if (upd_taken) begin
        wr_s               = 1'b1;
        nxt_entry_s.valid  = 1'b1;
        nxt_entry_s.tag    = tag_of(upd_pc);
        nxt_entry_s.target = upd_target;
        nxt_entry_s.ctr    = WT;
      end else begin
        wr_s = 1'b0;
      end
    end else begin
      wr_s = 1'b0;
    end
  end

  // Storage: async clear to invalid/weakly-not-taken, single write port.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem_r[i] <= '{valid: 1'b0, tag: 30'd0, target: 32'd0, ctr: WNT};
      end
    end else if (wr_s) begin
      mem_r[up_idx_s] <= nxt_entry_s;
    end
  end

endmodule

// File: rtl/pc_bpred.sv
// Fetch program counter with BTB-based next-PC prediction and EX redirect.
module pc_bpred
  import pc_bpred_pkg::*;
#(
  parameter logic [31:0] PC_INIT     = 32'd0,
  parameter int          BTB_ENTRIES = 16,
  parameter bit          BTB_EN      = 1'b1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        halt,
  input  logic        stall,
  input  logic        ex_update,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_mispredict,
  input  logic [31:0] ex_correct_pc,
  output logic [31:0] iaddr,
  output logic        pred_taken,
  output logic [31:0] pred_npc
);

  logic [31:0] iaddr_r;
  logic        btb_hit_s;
  logic        btb_ctr_msb_s;
  logic [31:0] btb_target_s;
  logic        btb_wr_s;
  logic        pred_taken_s;
  logic [31:0] pred_npc_s;

  // With prediction disabled the table is never written and so never hits.
  assign btb_wr_s = BTB_EN && ex_update;

  pc_bpred_btb #(.ENTRIES(BTB_ENTRIES)) u_btb (
    .CLK            (CLK),
    .nRST           (nRST),
    .lookup_pc      (iaddr_r),
    .lookup_hit     (btb_hit_s),
    .lookup_ctr_msb (btb_ctr_msb_s),
    .lookup_target  (btb_target_s),
    .upd_en         (btb_wr_s),
    .upd_pc         (ex_pc),
    .upd_taken      (ex_taken),
    .upd_target     (ex_target)
  );

  // Next-PC prediction for the address currently being fetched.
  always_comb begin
    pred_taken_s = 1'b0;
    pred_npc_s   = iaddr_r + PC_STEP;
    if (BTB_EN && btb_hit_s && btb_ctr_msb_s) begin
      pred_taken_s = 1'b1;
      pred_npc_s   = btb_target_s;
    end else begin
      pred_taken_s = 1'b0;
      pred_npc_s   = iaddr_r + PC_STEP;
    end
  end

  // PC register: halt beats redirect, redirect beats stall and icache miss.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      iaddr_r <= PC_INIT;
    end else if (halt) begin
      iaddr_r <= iaddr_r;
    end else if (ex_mispredict) begin
      iaddr_r <= ex_correct_pc;
    end else if (stall || !ihit) begin
      iaddr_r <= iaddr_r;
    end else begin
      iaddr_r <= pred_npc_s;
    end
  end

  assign iaddr      = iaddr_r;
  assign pred_taken = pred_taken_s;
  assign pred_npc   = pred_npc_s;

endmodule

// File: tb/tb_pc_bpred.sv
// Self-checking bench for pc_bpred against a table-level reference model.
module tb_pc_bpred;

  localparam int N     = 16;
  localparam int IDX_W = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, halt, stall, ex_update, ex_taken, ex_mispredict;
  logic [31:0] ex_pc, ex_target, ex_correct_pc;
  logic [31:0] iaddr, pred_npc;
  logic        pred_taken;

  int errors = 0;
  int checks = 0;

  // Reference model: per-index valid/tag/target and a counter 0..3.
  bit          mv   [N];
  bit [31:0]   mtag [N];
  bit [31:0]   mtgt [N];
  int          mctr [N];
  bit [31:0]   mpc;
  bit          e_t;
  bit [31:0]   e_npc;

  pc_bpred #(.PC_INIT(32'd0), .BTB_ENTRIES(N), .BTB_EN(1'b1)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .halt(halt), .stall(stall),
    .ex_update(ex_update), .ex_pc(ex_pc), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_mispredict(ex_mispredict),
    .ex_correct_pc(ex_correct_pc), .iaddr(iaddr), .pred_taken(pred_taken),
    .pred_npc(pred_npc)
  );

  always #5 CLK = ~CLK;

  function automatic void model_clear();
    for (int i = 0; i < N; i++) begin
      mv[i] = 1'b0; mtag[i] = 32'd0; mtgt[i] = 32'd0; mctr[i] = 1;
    end
    mpc = 32'd0;
  endfunction

  function automatic void model_look(input bit [31:0] pc, output bit t, output bit [31:0] npc);
    int idx;
    idx = (pc >> 2) % N;
    t   = mv[idx] && (mtag[idx] == (pc >> (IDX_W + 2))) && (mctr[idx] >= 2);
    npc = t ? mtgt[idx] : pc + 32'd4;
  endfunction

  // Drive one cycle of inputs, clock it, and advance the model the same way.
  task automatic drive(input bit h, input bit st, input bit ih, input bit upd,
                       input bit [31:0] epc, input bit tk, input bit [31:0] etgt,
                       input bit mis, input bit [31:0] cpc);
    bit          t;
    bit [31:0]   npc;
    int          idx;
    bit          hit;
    halt = h; stall = st; ihit = ih; ex_update = upd; ex_pc = epc;
    ex_taken = tk; ex_target = etgt; ex_mispredict = mis; ex_correct_pc = cpc;
    @(posedge CLK);
    model_look(mpc, t, npc);
    if (h) mpc = mpc;
    else if (mis) mpc = cpc;
    else if (st || !ih) mpc = mpc;
    else mpc = npc;
    if (upd) begin
      idx = (epc >> 2) % N;
      hit = mv[idx] && (mtag[idx] == (epc >> (IDX_W + 2)));
      if (hit && tk) begin
        mctr[idx] = (mctr[idx] == 3) ? 3 : mctr[idx] + 1; mtgt[idx] = etgt;
      end else if (hit) begin
        mctr[idx] = (mctr[idx] == 0) ? 0 : mctr[idx] - 1;
      end else if (tk) begin
        mv[idx] = 1'b1; mtag[idx] = epc >> (IDX_W + 2); mtgt[idx] = etgt; mctr[idx] = 2;
      end
    end
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    halt = 0; stall = 0; ihit = 0; ex_update = 0; ex_pc = 0; ex_taken = 0;
    ex_target = 0; ex_mispredict = 0; ex_correct_pc = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    nRST = 1'b0;
    model_clear();
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (iaddr !== 32'd0 || pred_taken !== 1'b0 || pred_npc !== 32'd4) begin
      errors++;
      $display("FAIL reset: iaddr=%h pt=%b npc=%h required 0 0 4", iaddr, pred_taken, pred_npc);
    end
  endtask

  task automatic test_fetch();
    bit [31:0] exp_seq [3];
    exp_seq[0] = 32'h4; exp_seq[1] = 32'h8; exp_seq[2] = 32'hC;
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
      checks++;
      if (iaddr !== exp_seq[i] || pred_taken !== 1'b0) begin
        errors++; $display("FAIL seq%0d: iaddr=%h pt=%b required %h 0", i, iaddr, pred_taken, exp_seq[i]);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (iaddr !== 32'h8) begin errors++; $display("FAIL ihit_hold: iaddr=%h required 8", iaddr); end
    drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (iaddr !== 32'h8) begin errors++; $display("FAIL stall_hold: iaddr=%h required 8", iaddr); end
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (iaddr !== exp_seq[2]) begin errors++; $display("FAIL release: iaddr=%h required c", iaddr); end
  endtask

  task automatic test_train();
    do_reset();
    // Train and redirect to 0x10 in the same cycle; both must land.
    drive(0, 0, 1, 1, 32'h10, 1, 32'h40, 1, 32'h10);
    checks++;
    if (iaddr !== 32'h10 || pred_taken !== 1'b1 || pred_npc !== 32'h40) begin
      errors++; $display("FAIL train: iaddr=%h pt=%b npc=%h required 10 1 40", iaddr, pred_taken, pred_npc);
    end
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (iaddr !== 32'h40) begin errors++; $display("FAIL follow: iaddr=%h required 40", iaddr); end
  endtask

  task automatic test_saturation();
    bit exp_pt [7];
    bit tk_seq [7];
    // alloc(10) inc(11) inc(11) dec(10) dec(01) dec(00) dec(00)
    tk_seq = '{1, 1, 1, 0, 0, 0, 0};
    exp_pt = '{1, 1, 1, 1, 0, 0, 0};
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h20);
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 0, 1, 32'h20, tk_seq[i], 32'h60, 0, 0);
      checks++;
      if (pred_taken !== exp_pt[i] || pred_npc !== (exp_pt[i] ? 32'h60 : 32'h24)) begin
        errors++; $display("FAIL sat%0d: pt=%b npc=%h required %b", i, pred_taken, pred_npc, exp_pt[i]);
      end
    end
    // From the floor, one taken update must reach only weakly-not-taken.
    drive(0, 0, 0, 1, 32'h20, 1, 32'h60, 0, 0);
    checks++;
    if (pred_taken !== 1'b0) begin errors++; $display("FAIL sat_floor: pt=%b required 0", pred_taken); end
    drive(0, 0, 0, 1, 32'h20, 1, 32'h64, 0, 0);
    checks++;
    if (pred_taken !== 1'b1 || pred_npc !== 32'h64) begin
      errors++; $display("FAIL sat_retarget: pt=%b npc=%h required 1 64", pred_taken, pred_npc);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h80);
    checks++;
    if (iaddr !== 32'h80) begin errors++; $display("FAIL redirect: iaddr=%h required 80", iaddr); end
    drive(1, 0, 1, 0, 0, 0, 0, 1, 32'h100);
    checks++;
    if (iaddr !== 32'h80) begin errors++; $display("FAIL halt_redirect: iaddr=%h required 80", iaddr); end
  endtask

  task automatic test_alias();
    do_reset();
    drive(0, 0, 0, 1, 32'h10, 1, 32'h40, 0, 0);
    drive(0, 0, 0, 1, 32'h10 + 4 * N, 1, 32'h200, 1, 32'h10);
    checks++;
    if (iaddr !== 32'h10 || pred_taken !== 1'b0 || pred_npc !== 32'h14) begin
      errors++; $display("FAIL alias_evict: iaddr=%h pt=%b npc=%h required 10 0 14", iaddr, pred_taken, pred_npc);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h50);
    checks++;
    if (pred_taken !== 1'b1 || pred_npc !== 32'h200) begin
      errors++; $display("FAIL alias_hit: pt=%b npc=%h required 1 200", pred_taken, pred_npc);
    end
    // Weaken the same line while it is being looked up.
    ihit = 0; ex_update = 1; ex_pc = 32'h50; ex_taken = 0; ex_mispredict = 0;
    #1;
    checks++;
    if (pred_taken !== 1'b1) begin errors++; $display("FAIL same_cycle_old: pt=%b required 1", pred_taken); end
    drive(0, 0, 0, 1, 32'h50, 0, 32'h0, 0, 0);
    checks++;
    if (pred_taken !== 1'b0 || pred_npc !== 32'h54) begin
      errors++; $display("FAIL same_cycle_new: pt=%b npc=%h required 0 54", pred_taken, pred_npc);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(0, 0, 0, 1, 32'h0, 1, 32'h300, 1, 32'h0);
    checks++;
    if (pred_taken !== 1'b1) begin errors++; $display("FAIL pre_reset: pt=%b required 1", pred_taken); end
    drive(0, 0, 1, 0, 0, 0, 0, 1, 32'h44);
    ex_update = 1; ex_pc = 32'h0; ex_taken = 1; ex_target = 32'h300;
    ex_mispredict = 1; ex_correct_pc = 32'h88;
    #2 nRST = 1'b0;
    #1;
    checks++;
    if (iaddr !== 32'd0 || pred_taken !== 1'b0 || pred_npc !== 32'd4) begin
      errors++; $display("FAIL async_reset: iaddr=%h pt=%b npc=%h required 0 0 4", iaddr, pred_taken, pred_npc);
    end
    do_reset();
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 16) == 0, ($urandom % 8) == 0, ($urandom % 4) != 0,
            ($urandom % 2) == 0, $urandom_range(0, 31) << 2, ($urandom % 3) != 0,
            $urandom_range(0, 63) << 2, ($urandom % 10) == 0, $urandom_range(0, 63) << 2);
      model_look(mpc, e_t, e_npc);
      checks++;
      if (iaddr !== mpc || pred_taken !== e_t || pred_npc !== e_npc) begin
        errors++;
        if (bad < 5) $display("FAIL random%0d: iaddr=%h pt=%b npc=%h required %h %b %h",
                              i, iaddr, pred_taken, pred_npc, mpc, e_t, e_npc);
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_train();
    test_saturation();
    test_redirect();
    test_alias();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
